// File: rtl/imem_arbiter.sv
// Single-port instruction/data memory arbiter for fetch, LSU and VGA scanout.
// VGA has fixed priority, starved fetch/LSU override it, fetch and LSU share round-robin.
module imem_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_async,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [1:0]        lsu_be,
    input  logic              lsu_lock,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_gnt,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LSU   = 2'd2,
        OWN_VGA   = 2'd3
    } owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       rr_ptr;       // 0 = fetch preferred, 1 = LSU preferred
    logic       lock_active;
    logic [3:0] fetch_wait;
    logic [3:0] lsu_wait;
    logic [3:0] fetch_wait_next;
    logic [3:0] lsu_wait_next;
    owner_t     rd_owner;
    owner_t     rd_owner_next;

    // Grants are held low during reset so nothing issued then can return data.
    always_comb begin
        fetch_gnt = 1'b0;
        lsu_gnt   = 1'b0;
        vga_gnt   = 1'b0;
        if (!rst_async) begin
            if (lock_active && lsu_req)                      lsu_gnt   = 1'b1;
            else if (fetch_req && (fetch_wait >= LIMIT))     fetch_gnt = 1'b1;
            else if (lsu_req && (lsu_wait >= LIMIT))         lsu_gnt   = 1'b1;
            else if (vga_req)                                vga_gnt   = 1'b1;
            else if (fetch_req && (!rr_ptr || !lsu_req))     fetch_gnt = 1'b1;
            else if (lsu_req)                                lsu_gnt   = 1'b1;
        end
    end

    always_comb begin
        mem_en    = fetch_gnt | lsu_gnt | vga_gnt;
        mem_we    = lsu_gnt & lsu_we;
        mem_be    = (lsu_gnt && lsu_we) ? lsu_be : 2'b11;
        mem_wdata = lsu_wdata;
        mem_addr  = fetch_addr;
        if (lsu_gnt)      mem_addr = lsu_addr;
        else if (vga_gnt) mem_addr = vga_addr;
    end

    always_comb begin
        rd_owner_next = OWN_NONE;
        if (fetch_gnt)               rd_owner_next = OWN_FETCH;
        else if (vga_gnt)            rd_owner_next = OWN_VGA;
        else if (lsu_gnt && !lsu_we) rd_owner_next = OWN_LSU;
    end

    // Wait counters saturate at the limit and clear on grant or dropped request.
    always_comb begin
        fetch_wait_next = 4'd0;
        lsu_wait_next   = 4'd0;
        if (fetch_req && !fetch_gnt)
            fetch_wait_next = (fetch_wait < LIMIT) ? fetch_wait + 4'd1 : fetch_wait;
        if (lsu_req && !lsu_gnt)
            lsu_wait_next = (lsu_wait < LIMIT) ? lsu_wait + 4'd1 : lsu_wait;
    end

    always_ff @(posedge clk) begin
        if (rst_async) begin
            rr_ptr      <= 1'b0;
            lock_active <= 1'b0;
            fetch_wait  <= 4'd0;
            lsu_wait    <= 4'd0;
            rd_owner    <= OWN_NONE;
        end else begin
            if (fetch_gnt)    rr_ptr <= 1'b1;
            else if (lsu_gnt) rr_ptr <= 1'b0;
            // A locked grant cannot re-arm the lock.
            lock_active <= lsu_gnt & lsu_lock & ~lock_active;
            fetch_wait  <= fetch_wait_next;
            lsu_wait    <= lsu_wait_next;
            rd_owner    <= rd_owner_next;
        end
    end

    assign fetch_rvalid = (rd_owner == OWN_FETCH);
    assign lsu_rvalid   = (rd_owner == OWN_LSU);
    assign vga_rvalid   = (rd_owner == OWN_VGA);
    assign fetch_rdata  = mem_rdata;
    assign lsu_rdata    = mem_rdata;
    assign vga_rdata    = mem_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;
  localparam int AW = 13;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_async;
  logic          fetch_req, fetch_gnt, fetch_rvalid;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_rdata;
  logic          lsu_req, lsu_we, lsu_lock, lsu_gnt, lsu_rvalid;
  logic [1:0]    lsu_be;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic          vga_req, vga_gnt, vga_rvalid;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_rdata;
  logic          mem_en, mem_we;
  logic [1:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;
  logic [15:0] rd_val;

  logic [2:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_async(rst_async),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_be(lsu_be), .lsu_lock(lsu_lock),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    bad++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    fetch_req = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_lock = 1'b0;
    lsu_be = 2'b11; vga_req = 1'b0; lsu_wdata = '0;
    fetch_addr = 13'h0010; lsu_addr = 13'h0200; vga_addr = 13'h1fff;
  endtask

  // scoreboard: expected read-return owner (one-hot fetch,lsu,vga)
  always @(posedge clk) begin
    logic [2:0] rv;
    logic [2:0] exp_rv;
    rv = {fetch_rvalid === 1'b1, lsu_rvalid === 1'b1, vga_rvalid === 1'b1};
    if (rv != 3'b000) begin
      total++;
      if (exp_q.size() == 0) begin
        fail("sb_unexpected_rvalid", 32'(rv), 32'd0);
      end else begin
        exp_rv = exp_q.pop_front();
        if (rv !== exp_rv) fail("sb_owner", 32'(rv), 32'(exp_rv));
      end
      total++;
      if ((rv[2] && fetch_rdata !== mem_rdata) || (rv[1] && lsu_rdata !== mem_rdata) ||
          (rv[0] && vga_rdata !== mem_rdata))
        fail("sb_rdata", 32'(mem_rdata), 32'(mem_rdata));
    end
    if (rst_async === 1'b1) begin
      exp_q.delete();
    end else if (mem_en === 1'b1 && mem_we === 1'b0) begin
      exp_q.push_back({fetch_gnt, lsu_gnt, vga_gnt});
    end
  end

  initial begin
    rst_async = 1'b1;
    mem_rdata = '0;
    idle();

    vga_req = 1'b1; fetch_req = 1'b1;
    settle();
    total++; if ({fetch_gnt, lsu_gnt, vga_gnt} !== 3'b000) fail("rst0_gnt", {fetch_gnt, lsu_gnt, vga_gnt}, 3'b000);
    total++; if ({mem_en, mem_we} !== 2'b00) fail("rst0_en", {mem_en, mem_we}, 2'b00);

    next_cycle();
    rst_async = 1'b0; vga_req = 1'b0;
    settle();
    total++; if ({fetch_gnt, lsu_gnt, vga_gnt} !== 3'b100) fail("c1_gnt", {fetch_gnt, lsu_gnt, vga_gnt}, 3'b100);
    total++; if (mem_addr !== 13'h0010) fail("c1_addr", mem_addr, 13'h0010);

    next_cycle();
    rst_async = 1'b1; vga_req = 1'b1; lsu_req = 1'b1;
    settle();
    total++; if ({fetch_gnt, lsu_gnt, vga_gnt} !== 3'b000) fail("c2_gnt", {fetch_gnt, lsu_gnt, vga_gnt}, 3'b000);
    total++; if ({mem_en, mem_we} !== 2'b00) fail("c2_en", {mem_en, mem_we}, 2'b00);

    next_cycle();
    rst_async = 1'b0; vga_req = 1'b0;
    settle();
    total++; if ({fetch_rvalid, lsu_rvalid, vga_rvalid} !== 3'b000) fail("c3_rv", {fetch_rvalid, lsu_rvalid, vga_rvalid}, 3'b000);
    total++; if ({fetch_gnt, lsu_gnt, vga_gnt} !== 3'b100) fail("c3_gnt", {fetch_gnt, lsu_gnt, vga_gnt}, 3'b100);

    for (int i = 0; i < 5; i++) begin
      next_cycle();
      rd_val = 16'($urandom_range(0, 16'hffff));
      mem_rdata = rd_val;
      settle();
      if (i % 2 == 0) begin
        total++; if ({fetch_gnt, lsu_gnt, vga_gnt} !== 3'b010) fail("rr_gnt_l", {fetch_gnt, lsu_gnt, vga_gnt}, 3'b010);
        total++; if (mem_addr !== 13'h0200) fail("rr_addr_l", mem_addr, 13'h0200);
        total++; if ({fetch_rvalid, lsu_rvalid, vga_rvalid} !== 3'b100) fail("rr_rv_f", {fetch_rvalid, lsu_rvalid, vga_rvalid}, 3'b100);
        total++; if (fetch_rdata !== rd_val) fail("rr_rdata_f", fetch_rdata, rd_val);
      end else begin
        total++; if ({fetch_gnt, lsu_gnt, vga_gnt} !== 3'b100) fail("rr_gnt_f", {fetch_gnt, lsu_gnt, vga_gnt}, 3'b100);
        total++; if (mem_addr !== 13'h0010) fail("rr_addr_f", mem_addr, 13'h0010);
        total++; if ({fetch_rvalid, lsu_rvalid, vga_rvalid} !== 3'b010) fail("rr_rv_l", {fetch_rvalid, lsu_rvalid, vga_rvalid}, 3'b010);
        total++; if (lsu_rdata !== rd_val) fail("rr_rdata_l", lsu_rdata, rd_val);
      end
    end

    next_cycle();
    fetch_req = 1'b0; lsu_req = 1'b0; mem_rdata = 16'h2222;
    settle();
    total++; if ({fetch_rvalid, lsu_rvalid, vga_rvalid} !== 3'b010) fail("c9_rv", {fetch_rvalid, lsu_rvalid, vga_rvalid}, 3'b010);
    total++; if (lsu_rdata !== 16'h2222) fail("c9_rdata", lsu_rdata, 16'h2222);
    total++; if (mem_en !== 1'b0) fail("c9_en", mem_en, 1'b0);

    for (int i = 0; i < 6; i++) begin
      next_cycle();
      vga_req = 1'b1; fetch_req = 1'b1;
      settle();
      total++;
      if ({fetch_gnt, lsu_gnt, vga_gnt} !== ((i == 4) ? 3'b100 : 3'b001))
        fail("vs_gnt", {fetch_gnt, lsu_gnt, vga_gnt}, (i == 4) ? 3'b100 : 3'b001);
      total++;
      if ({fetch_rvalid, lsu_rvalid, vga_rvalid} !== ((i == 0) ? 3'b000 : ((i == 5) ? 3'b100 : 3'b001)))
        fail("vs_rv", {fetch_rvalid, lsu_rvalid, vga_rvalid}, (i == 0) ? 3'b000 : ((i == 5) ? 3'b100 : 3'b001));
      if (i == 4) begin
        total++; if (mem_addr !== 13'h0010) fail("vs_addr_f", mem_addr, 13'h0010);
      end
      if (i == 5) begin
        total++; if (mem_addr !== 13'h1fff) fail("vs_addr_v", mem_addr, 13'h1fff);
      end
    end

    next_cycle();
    idle();
    settle();
    total++; if ({fetch_rvalid, lsu_rvalid, vga_rvalid} !== 3'b001) fail("c16_rv", {fetch_rvalid, lsu_rvalid, vga_rvalid}, 3'b001);
    total++; if (mem_en !== 1'b0) fail("c16_en", mem_en, 1'b0);

    next_cycle();
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_lock = 1'b1; lsu_addr = 13'h0100;
    settle();
    total++; if ({fetch_gnt, lsu_gnt, vga_gnt} !== 3'b010) fail("c17_gnt", {fetch_gnt, lsu_gnt, vga_gnt}, 3'b010);
    total++; if (mem_we !== 1'b0) fail("c17_we", mem_we, 1'b0);
    total++; if (mem_addr !== 13'h0100) fail("c17_addr", mem_addr, 13'h0100);

    next_cycle();
    lsu_we = 1'b1; lsu_be = 2'b10; lsu_wdata = 16'hab00; lsu_lock = 1'b0;
    vga_req = 1'b1; mem_rdata = 16'h3333;
    settle();
    total++; if ({fetch_gnt, lsu_gnt, vga_gnt} !== 3'b010) fail("c18_gnt", {fetch_gnt, lsu_gnt, vga_gnt}, 3'b010);
    total++; if ({mem_en, mem_we, mem_be} !== 4'b1110) fail("c18_wr", {mem_en, mem_we, mem_be}, 4'b1110);
    total++; if (mem_wdata !== 16'hab00) fail("c18_wdata", mem_wdata, 16'hab00);
    total++; if ({fetch_rvalid, lsu_rvalid, vga_rvalid} !== 3'b010) fail("c18_rv", {fetch_rvalid, lsu_rvalid, vga_rvalid}, 3'b010);
    total++; if (lsu_rdata !== 16'h3333) fail("c18_rdata", lsu_rdata, 16'h3333);

    next_cycle();
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_be = 2'b11;
    settle();
    total++; if ({fetch_gnt, lsu_gnt, vga_gnt} !== 3'b001) fail("c19_gnt", {fetch_gnt, lsu_gnt, vga_gnt}, 3'b001);
    total++; if ({fetch_rvalid, lsu_rvalid, vga_rvalid} !== 3'b000) fail("c19_rv", {fetch_rvalid, lsu_rvalid, vga_rvalid}, 3'b000);

    next_cycle();
    vga_req = 1'b0;
    settle();
    total++; if ({fetch_rvalid, lsu_rvalid, vga_rvalid} !== 3'b001) fail("c20_rv", {fetch_rvalid, lsu_rvalid, vga_rvalid}, 3'b001);

    next_cycle();
    fetch_req = 1'b1;
    settle();
    total++; if ({fetch_gnt, lsu_gnt, vga_gnt} !== 3'b100) fail("c21_gnt", {fetch_gnt, lsu_gnt, vga_gnt}, 3'b100);

    next_cycle();
    lsu_req = 1'b1; lsu_lock = 1'b1; lsu_addr = 13'h0300;
    settle();
    total++; if ({fetch_gnt, lsu_gnt, vga_gnt} !== 3'b010) fail("c22_gnt", {fetch_gnt, lsu_gnt, vga_gnt}, 3'b010);
    total++; if ({fetch_rvalid, lsu_rvalid, vga_rvalid} !== 3'b100) fail("c22_rv", {fetch_rvalid, lsu_rvalid, vga_rvalid}, 3'b100);
    next_cycle();
    settle();
    total++; if ({fetch_gnt, lsu_gnt, vga_gnt} !== 3'b010) fail("c23_gnt", {fetch_gnt, lsu_gnt, vga_gnt}, 3'b010);
    total++; if ({fetch_rvalid, lsu_rvalid, vga_rvalid} !== 3'b010) fail("c23_rv", {fetch_rvalid, lsu_rvalid, vga_rvalid}, 3'b010);
    next_cycle();
    settle();
    total++; if ({fetch_gnt, lsu_gnt, vga_gnt} !== 3'b100) fail("c24_gnt", {fetch_gnt, lsu_gnt, vga_gnt}, 3'b100);
    total++; if ({fetch_rvalid, lsu_rvalid, vga_rvalid} !== 3'b010) fail("c24_rv", {fetch_rvalid, lsu_rvalid, vga_rvalid}, 3'b010);

    next_cycle();
    idle();
    settle();
    total++; if ({fetch_rvalid, lsu_rvalid, vga_rvalid} !== 3'b100) fail("c25_rv", {fetch_rvalid, lsu_rvalid, vga_rvalid}, 3'b100);
    total++; if (mem_en !== 1'b0) fail("c25_en", mem_en, 1'b0);

    next_cycle();
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 2'b00; lsu_wdata = 16'h1234;
    settle();
    total++; if ({fetch_gnt, lsu_gnt, vga_gnt} !== 3'b010) fail("c26_gnt", {fetch_gnt, lsu_gnt, vga_gnt}, 3'b010);
    total++; if ({mem_en, mem_we, mem_be} !== 4'b1100) fail("c26_wr", {mem_en, mem_we, mem_be}, 4'b1100);
    total++; if (mem_wdata !== 16'h1234) fail("c26_wdata", mem_wdata, 16'h1234);

    next_cycle();
    idle();
    settle();
    total++; if ({fetch_rvalid, lsu_rvalid, vga_rvalid} !== 3'b000) fail("c27_rv", {fetch_rvalid, lsu_rvalid, vga_rvalid}, 3'b000);

    for (int i = 0; i < 6; i++) begin
      next_cycle();
      vga_req = 1'b1; lsu_req = 1'b1; lsu_we = 1'b0;
      settle();
      total++;
      if ({fetch_gnt, lsu_gnt, vga_gnt} !== ((i == 4) ? 3'b010 : 3'b001))
        fail("vl_gnt", {fetch_gnt, lsu_gnt, vga_gnt}, (i == 4) ? 3'b010 : 3'b001);
      total++;
      if ({fetch_rvalid, lsu_rvalid, vga_rvalid} !== ((i == 0) ? 3'b000 : ((i == 5) ? 3'b010 : 3'b001)))
        fail("vl_rv", {fetch_rvalid, lsu_rvalid, vga_rvalid}, (i == 0) ? 3'b000 : ((i == 5) ? 3'b010 : 3'b001));
    end

    next_cycle();
    idle();
    settle();
    total++; if ({fetch_rvalid, lsu_rvalid, vga_rvalid} !== 3'b001) fail("c34_rv", {fetch_rvalid, lsu_rvalid, vga_rvalid}, 3'b001);
    total++; if (mem_en !== 1'b0) fail("c34_en", mem_en, 1'b0);

    next_cycle();
    settle();
    total++; if (exp_q.size() != 0) fail("sb_leftover", exp_q.size(), 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end
endmodule
